// File: rtl/mux_rr_sched.sv
// Round-robin burst scheduler for a shared 4-input mux: one owner at a time,
// held until it drops its request or MAX_BURST cycles elapse.
module mux_rr_sched #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       en
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] scan_start;
  logic [7:0] req_dbl;
  logic [3:0] req_rot;
  logic [1:0] win_off;
  logic [1:0] winner;
  logic       any_req;
  logic       burst_done;

  // While granted, the search starts just past the owner so the owner ranks last.
  assign scan_start = (state_q == GRANT) ? sel_q + 2'd1 : ptr_q;
  assign req_dbl    = {req, req};
  assign req_rot    = req_dbl[scan_start +: 4];
  assign any_req    = |req;
  assign burst_done = !req[sel_q] || (cnt_q == CNT_W'(MAX_BURST));

  always_comb begin
    win_off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req_rot[k]) win_off = 2'(k);
    end
  end

  assign winner = scan_start + win_off;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << winner;
          sel_d   = winner;
          en_d    = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!burst_done) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          ptr_d = sel_q + 2'd1;
          if (any_req) begin
            gnt_d = 4'b0001 << winner;
            sel_d = winner;
            cnt_d = CNT_W'(1);
          end else begin
            // sel keeps its last value; en=0 forces the mux output to zero.
            state_d = IDLE;
            gnt_d   = 4'b0000;
            en_d    = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        en_d    = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt = gnt_q;
  assign sel = sel_q;
  assign en  = en_q;

endmodule
